spi_snapshot_ctl: RTL and testbench
===================================

# spi_snapshot_ctl

Snapshot sequencer between the quadrature counters / time base and the SPI slave's parallel transmit word. It periodically latches the 32-bit timestamp and five 32-bit quadrature counts in the same cycle, so the frame is coherent. It then computes a bit-serial CRC-32 over those six words and commits the 224-bit frame to `tx_data`. A commit never happens while the SPI host has the slave selected, so a frame being shifted out is never altered mid-transfer.

## Interface
Parameters:
- `PERIOD`, 256: clock cycles between snapshot attempts; legal range 200..65535.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high; all state cleared.
- `ssel`  in  1  SPI slave select, active-low, asynchronous to `clk`.
- `time_in`  in  32  free-running timestamp.
- `ctr_in`  in  160  counters, `{ctr0, ctr1, ctr2, ctr3, ctr4}`, ctr0 in the MSBs.
- `tx_data`  out  224  `{time, ctr0..ctr4, crc}` for the SPI slave; reset 0.
- `busy`  out  1  high from CAPTURE through COMMIT/DISCARD; reset 0.
- `commit_tick`  out  1  one-cycle pulse when `tx_data` updates; reset 0.
- `drop_tick`  out  1  one-cycle pulse when a computed frame is discarded; reset 0.

## Operation
- `ssel` passes through a 2-flop synchronizer, giving `ssel_s`; reset value is 1 (deselected).
- Period counter runs 0..PERIOD-1 and wraps. `tick` fires when the count is PERIOD-1.
- `tick` is acted on only in IDLE. A tick in any other state is ignored; there is no queueing.
- FSM states and transitions:
  - IDLE: on `tick`, go to CAPTURE.
  - CAPTURE (1 cycle): latch `{time_in, ctr_in}` into a 192-bit work register. Initialise CRC to 0xFFFFFFFF and the bit counter to 0. Go to CRC.
  - CRC (192 cycles): feed work-register bits into the CRC, MSB first, one bit per cycle. Leave when the bit counter reaches 191.
    - If `ssel_s` was 0 on any CRC cycle (sticky `sel_seen` flag), go to DISCARD.
    - Otherwise go to COMMIT.
  - COMMIT (1 cycle):
    - If `ssel_s` is 1: load `tx_data <= {work, ~crc}`, pulse `commit_tick`, go to IDLE.
    - If `ssel_s` is 0: treat as DISCARD.
  - DISCARD (1 cycle): pulse `drop_tick`, go to IDLE. `tx_data` is unchanged.
- CRC definition: polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB first, no reflection, final XOR 0xFFFFFFFF.
- Width rules: `tx_data[223:192]` = time, `[191:160]` = ctr0 … `[63:32]` = ctr4, `[31:0]` = CRC.
- `reset` asserted mid-frame: state returns to IDLE, `tx_data` goes to 0, the period counter goes to 0, and no `commit_tick` is produced.

## Timing
- Latency from `tick` to `commit_tick`: 195 cycles. The tick cycle is followed by CAPTURE (1), CRC (192), COMMIT (1), and the pulse is visible on the next cycle edge.
- `tx_data` is stable whenever `ssel_s` = 0. Updates happen only on a COMMIT edge with `ssel_s` = 1.
- The synchronizer delays `ssel` by 2 cycles, and the SPI slave samples `tx_data` at select assertion. A select asserted within 2 cycles before a COMMIT edge can therefore see the new frame, not the old one. Either frame is self-consistent, so this is accepted.
- Commit rate is one frame per PERIOD cycles at most, given PERIOD ≥ 200.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `spi_frame_pkg`:
  - constants `FRAME_W` = 224, `PAYLOAD_W` = 192, `NCTR` = 5, `CRC_POLY` = 32'h04C11DB7, `CRC_INIT` = 32'hFFFFFFFF;
  - FSM state enum `{IDLE, CAPTURE, CRC, COMMIT, DISCARD}`.
- Sub-module `crc32_serial`, with ports `clk`, `reset`, `init`, `en`, `din`, `crc[31:0]`: a 1-bit-per-cycle LFSR that is reusable for the future MOSI-side command check.
- Top level holds the period counter, synchronizer, FSM, 192-bit work shift register, 8-bit bit counter and `tx_data` register.

## Test plan
- Reset with PERIOD=256 and `ssel`=1 held: `tx_data`=0 and `busy`=0. The first `commit_tick` arrives at cycle 255+195 after reset release.
- Counters ramping every clock, `ssel`=1: each committed frame's six words equal the input values at the CAPTURE cycle (coherence check). The CRC matches the bench golden model. With `time_in`=0 and `ctr_in`=0, `tx_data[223:32]`=0.
- `ssel` driven low for 10 cycles in the middle of CRC: `drop_tick` pulses once, there is no `commit_tick`, and `tx_data` holds its previous value. The next period commits normally.
- `ssel` held low across several whole periods: one `drop_tick` per period and `tx_data` never changes. After `ssel` rises, the next `tick` yields a `commit_tick`.
- `reset` asserted at CRC bit 100: all outputs are 0 on the next edge and no stray `commit_tick` appears. After release, the first commit occurs 255+195 cycles later.
- PERIOD=200: back-to-back commits are exactly 200 cycles apart and no ticks are lost.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI snapshot path: frame geometry, CRC-32
// constants, the sequencer state type and a single-bit CRC update helper.
package spi_frame_pkg;

   localparam int FRAME_W   = 224;
   localparam int PAYLOAD_W = 192;
   localparam int NCTR      = 5;

   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      CRC,
      COMMIT,
      DISCARD
   } state_t;

   // One MSB-first, non-reflected CRC-32 step for a single input bit.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc_in, input logic din);
      logic [31:0] nxt;
      nxt = {crc_in[30:0], 1'b0};
      if (crc_in[31] ^ din) begin
         nxt = nxt ^ CRC_POLY;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/crc32_serial.sv
// Bit-serial CRC-32 LFSR (poly 0x04C11DB7, MSB first, no reflection).
// The register holds the raw remainder; the consumer applies the final XOR.
// Ports:
//   clk, reset : clock, async active-high reset (clears remainder to 0)
//   init       : load CRC_INIT (has priority over en)
//   en         : absorb din this cycle
//   din        : serial data bit
//   crc        : current remainder
module crc32_serial
   import spi_frame_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [31:0] crc
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = crc32_step(crc_q, din);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/spi_snapshot_ctl.sv
// Snapshot sequencer: every PERIOD cycles captures timestamp + five counters
// in one cycle, runs a serial CRC-32 over the 192-bit payload and commits the
// 224-bit frame to tx_data, but only while the SPI host is not selecting us.
// Ports:
//   clk, reset   : clock, async active-high reset
//   ssel         : SPI slave select (active-low, asynchronous)
//   time_in      : timestamp
//   ctr_in       : {ctr0..ctr4}, ctr0 in the MSBs
//   tx_data      : {time, ctr0..ctr4, crc}
//   busy         : sequencer is between CAPTURE and COMMIT/DISCARD
//   commit_tick  : one-cycle pulse when tx_data updates
//   drop_tick    : one-cycle pulse when a computed frame is thrown away
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the period tick
// CAPTURE | latch {time_in, ctr_in}, seed CRC, clear bit counter
// CRC     | 192 cycles, one payload bit per cycle into the CRC
// COMMIT  | publish frame if still deselected, else drop it
// DISCARD | select was seen during CRC; drop frame
module spi_snapshot_ctl
   import spi_frame_pkg::*;
#(
   parameter int PERIOD = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ssel,
   input  logic [31:0]          time_in,
   input  logic [NCTR*32-1:0]   ctr_in,
   output logic [FRAME_W-1:0]   tx_data,
   output logic                 busy,
   output logic                 commit_tick,
   output logic                 drop_tick
);

   logic [15:0]          period_q, period_d;
   logic                 tick;
   logic                 sync1_q, ssel_s_q;
   state_t               state_q, state_d;
   logic [PAYLOAD_W-1:0] work_q, work_d;
   logic [7:0]           bitcnt_q, bitcnt_d;
   logic                 sel_seen_q, sel_seen_d;
   logic [FRAME_W-1:0]   tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 commit_q, commit_d;
   logic                 drop_q, drop_d;
   logic [31:0]          crc_w;

   assign tick     = (period_q == 16'(PERIOD - 1));
   assign period_d = tick ? 16'd0 : period_q + 16'd1;

   // The work register rotates rather than shifts, so after 192 CRC cycles
   // it holds the original payload again and can be committed directly.
   crc32_serial u_crc (
      .clk   (clk),
      .reset (reset),
      .init  (state_q == CAPTURE),
      .en    (state_q == CRC),
      .din   (work_q[PAYLOAD_W-1]),
      .crc   (crc_w)
   );

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      bitcnt_d   = bitcnt_q;
      sel_seen_d = sel_seen_q;
      tx_d       = tx_q;
      commit_d   = 1'b0;
      drop_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            work_d     = {time_in, ctr_in};
            bitcnt_d   = 8'd0;
            sel_seen_d = 1'b0;
            state_d    = CRC;
         end
         CRC: begin
            work_d   = {work_q[PAYLOAD_W-2:0], work_q[PAYLOAD_W-1]};
            bitcnt_d = bitcnt_q + 8'd1;
            if (!ssel_s_q) begin
               sel_seen_d = 1'b1;
            end
            // Include the current cycle's select, not only the sticky flag.
            if (bitcnt_q == 8'd191) begin
               state_d = (sel_seen_q || !ssel_s_q) ? DISCARD : COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (ssel_s_q) begin
               tx_d     = {work_q, ~crc_w};
               commit_d = 1'b1;
            end else begin
               drop_d = 1'b1;
            end
         end
         DISCARD: begin
            drop_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q   <= '0;
         sync1_q    <= 1'b1;
         ssel_s_q   <= 1'b1;
         state_q    <= IDLE;
         work_q     <= '0;
         bitcnt_q   <= '0;
         sel_seen_q <= 1'b0;
         tx_q       <= '0;
         busy_q     <= 1'b0;
         commit_q   <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         period_q   <= period_d;
         sync1_q    <= ssel;
         ssel_s_q   <= sync1_q;
         state_q    <= state_d;
         work_q     <= work_d;
         bitcnt_q   <= bitcnt_d;
         sel_seen_q <= sel_seen_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         commit_q   <= commit_d;
         drop_q     <= drop_d;
      end
   end

   assign tx_data     = tx_q;
   assign busy        = busy_q;
   assign commit_tick = commit_q;
   assign drop_tick   = drop_q;

endmodule

// File: tb/tb_spi_snapshot_ctl.sv
// Bench for spi_snapshot_ctl: two instances (PERIOD 256 and 200) share the
// stimulus. A reference model decides, per period, whether the frame commits
// or drops and what tx_data must hold; a monitor checks the DUT pulses,
// tx_data and busy against those expectations.
module tb_spi_snapshot_ctl;

   logic         clk = 1'b0;
   logic         reset;
   logic         ssel;
   logic [31:0]  time_in;
   logic [159:0] ctr_in;
   logic [223:0] tx_a, tx_b;
   logic         busy_a, busy_b, ct_a, ct_b, dt_a, dt_b;

   always #10 clk = ~clk;

   spi_snapshot_ctl #(.PERIOD(256)) u_dut (
      .clk(clk), .reset(reset), .ssel(ssel), .time_in(time_in), .ctr_in(ctr_in),
      .tx_data(tx_a), .busy(busy_a), .commit_tick(ct_a), .drop_tick(dt_a)
   );

   spi_snapshot_ctl #(.PERIOD(200)) u_dut200 (
      .clk(clk), .reset(reset), .ssel(ssel), .time_in(time_in), .ctr_in(ctr_in),
      .tx_data(tx_b), .busy(busy_b), .commit_tick(ct_b), .drop_tick(dt_b)
   );

   typedef struct {
      bit           commit;
      int           cyc;
      logic [223:0] tx;
   } ev_t;

   ev_t          evq[2][$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   bit           run = 0;
   logic [191:0] hist_frame[1024];
   bit           hist_ssel[1024];
   logic [223:0] model_tx[2];
   logic [223:0] last_tx[2];
   logic [31:0]  base[6];

   function automatic logic [31:0] golden_crc(input logic [191:0] p);
      logic [31:0] c;
      bit          fb;
      c = 32'hFFFFFFFF;
      for (int i = 191; i >= 0; i--) begin
         fb = c[31] ^ p[i];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C11DB7;
      end
      return ~c;
   endfunction

   // Busy spans CAPTURE..COMMIT: cycles tick+1 .. tick+194 of each period.
   function automatic bit exp_busy(input int p, input int c);
      if (c < p) return 1'b0;
      return ((c - p) % p) <= 193;
   endfunction

   task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Called once the select window of a period (cycles t..t+192) is known.
   task automatic model_step(input int k, input int p, input int c);
      int  t;
      bit  ok;
      ev_t e;
      if (c < p - 1 + 192) return;
      t = c - 192;
      if ((t % p) != p - 1) return;
      ok = 1'b1;
      for (int j = t; j <= t + 192; j++) if (!hist_ssel[j % 1024]) ok = 1'b0;
      if (ok) model_tx[k] = {hist_frame[(t + 1) % 1024], golden_crc(hist_frame[(t + 1) % 1024])};
      e.commit = ok;
      e.cyc    = t + 195;
      e.tx     = model_tx[k];
      evq[k].push_back(e);
   endtask

   task automatic drive_cycle(input int c, input bit s, input bit zero);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = c;
      run   = 1'b1;
      ssel  = s;
      if (zero) begin
         time_in = '0;
         ctr_in  = '0;
      end else begin
         time_in = base[0] + 32'(c);
         for (int k = 0; k < 5; k++) ctr_in[159 - 32*k -: 32] = base[k + 1] + 32'(c * (k + 3));
      end
      hist_ssel[c % 1024]  = s;
      hist_frame[c % 1024] = {time_in, ctr_in};
      model_step(0, 256, c);
      model_step(1, 200, c);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      run   = 1'b0;
      evq[0].delete();
      evq[1].delete();
      for (int k = 0; k < 2; k++) begin
         model_tx[k] = '0;
         last_tx[k]  = '0;
      end
      for (int k = 0; k < 6; k++) base[k] = $urandom;
      @(negedge clk);
      chk("reset_tx_a", tx_a, '0);
      chk("reset_tx_b", tx_b, '0);
      chk("reset_flags", 224'({busy_a, ct_a, dt_a, busy_b, ct_b, dt_b}), '0);
      repeat (3) @(posedge clk);
   endtask

   task automatic monitor_inst(input int k, input int p, input logic ct, input logic dt,
                               input logic [223:0] tx, input logic bz);
      ev_t e;
      while (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
         e = evq[k].pop_front();
         checks++;
         errors++;
         $display("FAIL missed_event inst%0d want_commit=%0d want_cycle=%0d now=%0d",
                  k, e.commit, e.cyc, cyc);
      end
      if (ct || dt) begin
         if (evq[k].size() == 0 || evq[k][0].cyc != cyc) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse inst%0d cycle=%0d got commit=%0b drop=%0b want none",
                     k, cyc, ct, dt);
         end else begin
            e = evq[k].pop_front();
            chk($sformatf("pulse_kind%0d", k), 224'({ct, dt}), e.commit ? 224'd2 : 224'd1);
            last_tx[k] = e.tx;
         end
      end
      chk($sformatf("tx_data%0d", k), tx, last_tx[k]);
      chk($sformatf("busy%0d", k), 224'(bz), 224'(exp_busy(p, cyc)));
   endtask

   always @(negedge clk) begin
      if (run && !reset) begin
         monitor_inst(0, 256, ct_a, dt_a, tx_a, busy_a);
         monitor_inst(1, 200, ct_b, dt_b, tx_b, busy_b);
      end
   end

   initial begin
      bit s;
      bit z;
      reset   = 1'b1;
      ssel    = 1'b1;
      time_in = '0;
      ctr_in  = '0;

      // Segment 1: normal commits, zero frame, short select inside CRC,
      // select held low over several periods, then recovery.
      apply_reset();
      for (int c = 0; c < 2800; c++) begin
         s = 1'b1;
         z = 1'b0;
         if (c >= 1379 && c <= 1388) s = 1'b0;
         if (c >= 1586 && c < 2354) s = 1'b0;
         if (c >= 712 && c < 868) z = 1'b1;
         drive_cycle(c, s, z);
      end

      // Segment 2: reset lands at CRC bit 100 of the first 256-cycle frame.
      apply_reset();
      for (int c = 0; c < 357; c++) drive_cycle(c, 1'b1, 1'b0);
      apply_reset();

      // Segment 3: restart timing and back-to-back 200-cycle commits.
      for (int c = 0; c < 1000; c++) drive_cycle(c, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
